// File: rtl/maxpool_row_pair_if.sv
// Column-pair stream in, pooled write strobe out.
// The slave modport is the pooling stage; master is its environment
// (upstream ReLU driver plus downstream memory writer).
interface maxpool_row_pair_if #(
  parameter int BIT_DEPTH       = 8,
  parameter int DEST_ADDR_WIDTH = 10
);
  logic                       in_valid;
  logic                       in_ready;
  logic [BIT_DEPTH-1:0]       in_data1;
  logic [BIT_DEPTH-1:0]       in_data2;
  logic                       wr_en;
  logic [DEST_ADDR_WIDTH-1:0] out_addr;
  logic [BIT_DEPTH-1:0]       out_data;

  modport master (
    output in_valid, in_data1, in_data2,
    input  in_ready, wr_en, out_addr, out_data
  );

  modport slave (
    input  in_valid, in_data1, in_data2,
    output in_ready, wr_en, out_addr, out_data
  );
endinterface

// File: rtl/maxpool_row_pair.sv
// Streaming 2x2 max-pool over a row pair: vertical max per column, then
// horizontal max over adjacent columns with stride 1 or 2. Each pooled
// value is written to base_addr + output index, one cycle after its beat.
module maxpool_row_pair #(
  parameter int BIT_DEPTH       = 8,
  parameter int DEST_ADDR_WIDTH = 10,
  parameter int COL_CNT_WIDTH   = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 stride,
  input  logic [COL_CNT_WIDTH-1:0]   row_len,
  input  logic [DEST_ADDR_WIDTH-1:0] base_addr,
  output logic                       busy,
  output logic                       done,
  maxpool_row_pair_if.slave          bus
);

  typedef enum logic [1:0] {IDLE, ACCEPT, DONE} state_t;

  state_t                     state, state_n;
  logic [1:0]                 stride_q;
  logic [COL_CNT_WIDTH-1:0]   row_len_q;
  logic [DEST_ADDR_WIDTH-1:0] base_q;
  logic [COL_CNT_WIDTH-1:0]   col_cnt;
  logic [COL_CNT_WIDTH-1:0]   out_idx;
  logic [BIT_DEPTH-1:0]       prev;
  logic                       wr_en_q;
  logic [DEST_ADDR_WIDTH-1:0] out_addr_q;
  logic [BIT_DEPTH-1:0]       out_data_q;

  logic                       in_ready_c;
  logic                       cfg_ok;
  logic                       launch;
  logic                       beat;
  logic                       last_col;
  logic                       emit;
  logic [BIT_DEPTH-1:0]       vmax;
  logic [BIT_DEPTH-1:0]       pooled;

  assign cfg_ok   = ((stride == 2'd1) || (stride == 2'd2)) && (row_len >= COL_CNT_WIDTH'(2));
  assign beat     = bus.in_valid && in_ready_c;
  assign last_col = (col_cnt == row_len_q - COL_CNT_WIDTH'(1));
  assign vmax     = (bus.in_data1 >= bus.in_data2) ? bus.in_data1 : bus.in_data2;
  assign pooled   = (prev >= vmax) ? prev : vmax;
  // Stride 2 only pools the non-overlapping pairs (cols 0/1, 2/3, ...).
  assign emit     = beat && (col_cnt != '0) && ((stride_q == 2'd1) || col_cnt[0]);

  assign bus.in_ready = in_ready_c;
  assign bus.wr_en    = wr_en_q;
  assign bus.out_addr = out_addr_q;
  assign bus.out_data = out_data_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state decode and state-derived status outputs
  always_comb begin
    state_n    = state;
    in_ready_c = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    launch     = 1'b0;
    case (state)
      IDLE: begin
        if (start && cfg_ok) begin
          launch  = 1'b1;
          state_n = ACCEPT;
        end
      end
      ACCEPT: begin
        in_ready_c = 1'b1;
        busy       = 1'b1;
        if (bus.in_valid && last_col) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Configuration latch, column tracking and registered write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stride_q   <= '0;
      row_len_q  <= '0;
      base_q     <= '0;
      col_cnt    <= '0;
      out_idx    <= '0;
      prev       <= '0;
      wr_en_q    <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      wr_en_q <= emit;
      if (launch) begin
        stride_q  <= stride;
        row_len_q <= row_len;
        base_q    <= base_addr;
        col_cnt   <= '0;
        out_idx   <= '0;
      end
      if (beat) begin
        prev    <= vmax;
        col_cnt <= col_cnt + COL_CNT_WIDTH'(1);
      end
      if (emit) begin
        out_data_q <= pooled;
        out_addr_q <= base_q + DEST_ADDR_WIDTH'(out_idx);
        out_idx    <= out_idx + COL_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_maxpool_row_pair.sv
// Directed bench for maxpool_row_pair with a write scoreboard.
module tb_maxpool_row_pair;

  localparam int BD = 8;
  localparam int AW = 10;
  localparam int CW = 6;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    stride;
  logic [CW-1:0] row_len;
  logic [AW-1:0] base_addr;
  logic          busy;
  logic          done;

  maxpool_row_pair_if #(.BIT_DEPTH(BD), .DEST_ADDR_WIDTH(AW)) bus ();

  maxpool_row_pair #(
    .BIT_DEPTH(BD), .DEST_ADDR_WIDTH(AW), .COL_CNT_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stride    (stride),
    .row_len   (row_len),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [BD-1:0] d;
  } wr_t;

  wr_t q[$];

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;

  // Reference model state (spec-level behaviour)
  int            m_state;   // 0 idle, 1 accept, 2 done
  logic [1:0]    m_stride;
  int            m_len;
  logic [AW-1:0] m_base;
  int            m_col;
  int            m_idx;
  logic [BD-1:0] m_prev;
  logic [AW-1:0] m_last_a;
  logic [BD-1:0] m_last_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, model, edge, check at next negedge.
  task automatic step(input logic st, input logic [1:0] s, input logic [CW-1:0] len,
                      input logic [AW-1:0] base, input logic v,
                      input logic [BD-1:0] d1, input logic [BD-1:0] d2);
    logic [BD-1:0] vm;
    logic          exp_wr;
    wr_t           e;
    start = st; stride = s; row_len = len; base_addr = base;
    bus.in_valid = v; bus.in_data1 = d1; bus.in_data2 = d2;
    case (m_state)
      0: if (st && (s == 2'd1 || s == 2'd2) && len >= 2) begin
           m_state = 1; m_stride = s; m_len = int'(len); m_base = base;
           m_col = 0; m_idx = 0;
         end
      1: if (v) begin
           vm = (d1 > d2) ? d1 : d2;
           if (m_col > 0 && (m_stride == 2'd1 || (m_col % 2) == 1)) begin
             e.a = m_base + AW'(m_idx);
             e.d = (m_prev > vm) ? m_prev : vm;
             q.push_back(e);
             m_idx++;
           end
           m_prev = vm;
           if (m_col == m_len - 1) m_state = 2;
           m_col++;
         end
      default: m_state = 0;
    endcase
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("in_ready", 32'(bus.in_ready), 32'(m_state == 1));
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("done", 32'(done), 32'(m_state == 2));
    exp_wr = (q.size() != 0);
    chk("wr_en", 32'(bus.wr_en), 32'(exp_wr));
    if (bus.wr_en) wr_seen++;
    if (exp_wr) begin
      e = q.pop_front();
      m_last_a = e.a;
      m_last_d = e.d;
    end
    chk("out_addr", 32'(bus.out_addr), 32'(m_last_a));
    chk("out_data", 32'(bus.out_data), 32'(m_last_d));
  endtask

  task automatic go(input logic [1:0] s, input logic [CW-1:0] len, input logic [AW-1:0] base);
    wr_seen = 0;
    step(1'b1, s, len, base, 1'b0, '0, '0);
  endtask

  task automatic beat(input logic [BD-1:0] d1, input logic [BD-1:0] d2);
    step(1'b0, 2'd0, '0, '0, 1'b1, d1, d2);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
    chk({tag, "_busy"},     32'(busy),         32'd0);
    chk({tag, "_done"},     32'(done),         32'd0);
    chk({tag, "_addr"},     32'(bus.out_addr), 32'd0);
    chk({tag, "_data"},     32'(bus.out_data), 32'd0);
  endtask

  initial begin
    m_state = 0; m_stride = '0; m_len = 0; m_base = '0; m_col = 0; m_idx = 0;
    m_prev = '0; m_last_a = '0; m_last_d = '0;
    rst = 1'b0; start = 1'b0; stride = '0; row_len = '0; base_addr = '0;
    bus.in_valid = 1'b0; bus.in_data1 = '0; bus.in_data2 = '0;

    @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b1;
    idle();

    // 1: stride 1, row_len 4 -> 9@010, 9@011, 8@012
    go(2'd1, 6'd4, 10'h010);
    beat(8'd3, 8'd7); beat(8'd9, 8'd2); beat(8'd5, 8'd5); beat(8'd0, 8'd8);
    chk("t1_done_with_last_wr", 32'({done, bus.wr_en}), 32'b11);
    chk("t1_last_data", 32'(bus.out_data), 32'd8);
    idle();
    chk("t1_writes", 32'(wr_seen), 32'd3);

    // 2: stride 2, row_len 5 -> 4@020, 6@021, trailing column dropped
    go(2'd2, 6'd5, 10'h020);
    beat(8'd1, 8'd0); beat(8'd2, 8'd4); beat(8'd6, 8'd6); beat(8'd0, 8'd2); beat(8'd9, 8'd3);
    chk("t2_done_no_wr", 32'({done, bus.wr_en}), 32'b10);
    idle();
    chk("t2_writes", 32'(wr_seen), 32'd2);
    chk("t2_last_data", 32'(bus.out_data), 32'd6);

    // 3: stride 2 with gaps and a mid-pass start that must be ignored
    go(2'd2, 6'd4, 10'h040);
    beat(8'd5, 8'd1); idle();
    beat(8'd2, 8'd7); idle(); idle();
    step(1'b1, 2'd1, 6'd3, 10'h100, 1'b1, 8'd4, 8'd4);
    idle(); idle(); idle();
    beat(8'd3, 8'd9);
    idle();
    chk("t3_writes", 32'(wr_seen), 32'd2);
    chk("t3_last_addr", 32'(bus.out_addr), 32'h041);

    // 4: illegal starts and in_valid while idle are ignored
    wr_seen = 0;
    step(1'b1, 2'd3, 6'd4, 10'h000, 1'b0, '0, '0);
    step(1'b1, 2'd0, 6'd4, 10'h000, 1'b0, '0, '0);
    step(1'b1, 2'd1, 6'd1, 10'h000, 1'b0, '0, '0);
    step(1'b0, 2'd0, '0, '0, 1'b1, 8'd5, 8'd5);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_writes", 32'(wr_seen), 32'd0);

    // 5: address wrap -> 20@3FF, 20@000
    go(2'd1, 6'd3, 10'h3FF);
    beat(8'd10, 8'd0); beat(8'd3, 8'd20);
    chk("t5_addr_first", 32'(bus.out_addr), 32'h3FF);
    beat(8'd15, 8'd15);
    chk("t5_addr_wrap", 32'(bus.out_addr), 32'h000);
    idle();

    // 6: reset mid-pass, then a fresh full pass
    go(2'd1, 6'd6, 10'h080);
    beat(8'd1, 8'd2); beat(8'd3, 8'd4);
    rst = 1'b0;
    #1;
    chk_zero_outputs("t6_async");
    m_state = 0; m_last_a = '0; m_last_d = '0; q.delete();
    wr_seen = 0;
    beat(8'd7, 8'd7); beat(8'd9, 8'd1);
    chk("t6_no_wr_in_reset", 32'(wr_seen), 32'd0);
    rst = 1'b1;
    go(2'd1, 6'd6, 10'h080);
    beat(8'd1, 8'd2); beat(8'd3, 8'd4);
    chk("t6_first_addr", 32'(bus.out_addr), 32'h080);
    beat(8'd0, 8'd1); beat(8'd6, 8'd2); beat(8'd5, 8'd5); beat(8'd8, 8'd0);
    idle();
    chk("t6_writes", 32'(wr_seen), 32'd5);
    chk("t6_last_addr", 32'(bus.out_addr), 32'h084);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
